agg_ctrl: RTL and testbench

Sequencing controller for the aggregation/activation stage of the neural-network accelerator. It accepts a stream of signed partial products from the ALU side. For each neuron it accumulates them, with saturation, over a configured fan-in, then applies ReLU. It presents one activated result per neuron on a valid/ready output. It walks through a configured number of neurons per layer and signals completion, so the layer scheduler only has to issue `start` and consume results.

---
 rtl/agg_ctrl_if.sv | 23 ++
 rtl/agg_ctrl.sv | 147 ++++++++++++++
 tb/tb_agg_ctrl.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/agg_ctrl_if.sv
// Purpose: partial-product input stream and activated-result output stream of agg_ctrl.
// Latency: none, wires only.
// Backpressure: valid/ready on both streams; master is the producer/consumer side, slave is agg_ctrl.
interface agg_ctrl_if #(
  parameter int agg_width = 12
);
  logic                 in_valid;
  logic [agg_width-1:0] in_data;
  logic                 in_ready;
  logic                 out_valid;
  logic [agg_width-1:0] out_data;
  logic                 out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/agg_ctrl.sv
// Purpose: per-neuron saturating accumulate over fan-in, ReLU, one result per neuron, layer done pulse.
// Latency: last input handshake at edge t -> ACT in t+1 -> out_valid from t+2; done one cycle after final output handshake.
// Backpressure: in_ready only in ACCUM; OUT holds out_valid/out_data until out_ready, stalling all input.
module agg_ctrl #(
  parameter int agg_width = 12,
  parameter int cnt_width = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [cnt_width-1:0] cfg_fanin,
  input  logic [cnt_width-1:0] cfg_neurons,
  agg_ctrl_if.slave            bus,
  output logic [cnt_width-1:0] neuron_idx,
  output logic                 sat_flag,
  output logic                 busy,
  output logic                 done
);

  localparam logic [1:0] st_idle  = 2'd0;
  localparam logic [1:0] st_accum = 2'd1;
  localparam logic [1:0] st_act   = 2'd2;
  localparam logic [1:0] st_out   = 2'd3;

  localparam logic [agg_width-1:0] acc_max = {1'b0, {(agg_width-1){1'b1}}};
  localparam logic [agg_width-1:0] acc_min = {1'b1, {(agg_width-1){1'b0}}};
  localparam logic [cnt_width-1:0] cnt_one = cnt_width'(1);

  logic [1:0]           state_q, state_d;
  logic [cnt_width-1:0] fanin_q, fanin_d;
  logic [cnt_width-1:0] neurons_q, neurons_d;
  logic [agg_width-1:0] acc_q, acc_d;
  logic [cnt_width-1:0] cnt_q, cnt_d;
  logic [cnt_width-1:0] idx_q, idx_d;
  logic                 sat_q, sat_d;
  logic [agg_width-1:0] out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;
  logic                 done_q, done_d;
  logic [agg_width:0]   sum_w;

  // One extra bit of headroom: the top two bits differ exactly when the sum overflowed.
  always_comb begin
    sum_w = {acc_q[agg_width-1], acc_q} + {bus.in_data[agg_width-1], bus.in_data};
  end

  // Next-state and datapath control for the IDLE/ACCUM/ACT/OUT sequence.
  always_comb begin
    state_d     = state_q;
    fanin_d     = fanin_q;
    neurons_d   = neurons_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    sat_d       = sat_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    case (state_q)
      st_idle: begin
        if (start) begin
          fanin_d   = cfg_fanin;
          neurons_d = cfg_neurons;
          acc_d     = '0;
          cnt_d     = '0;
          idx_d     = '0;
          sat_d     = 1'b0;
          if (cfg_fanin == '0 || cfg_neurons == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = st_accum;
          end
        end
      end
      st_accum: begin
        if (bus.in_valid) begin
          if (sum_w[agg_width] != sum_w[agg_width-1]) begin
            acc_d = sum_w[agg_width] ? acc_min : acc_max;
            sat_d = 1'b1;
          end else begin
            acc_d = sum_w[agg_width-1:0];
          end
          cnt_d = cnt_q + cnt_one;
          // Compare before incrementing so a fan-in of all-ones never wraps.
          if (cnt_q == fanin_q - cnt_one) begin
            state_d = st_act;
          end
        end
      end
      st_act: begin
        out_data_d  = acc_q[agg_width-1] ? '0 : acc_q;
        out_valid_d = 1'b1;
        state_d     = st_out;
      end
      default: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          if (idx_q == neurons_q - cnt_one) begin
            done_d  = 1'b1;
            state_d = st_idle;
          end else begin
            idx_d   = idx_q + cnt_one;
            acc_d   = '0;
            cnt_d   = '0;
            sat_d   = 1'b0;
            state_d = st_accum;
          end
        end
      end
    endcase
  end

  // State and output registers; reset aborts any layer in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= st_idle;
      fanin_q     <= '0;
      neurons_q   <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      sat_q       <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      fanin_q     <= fanin_d;
      neurons_q   <= neurons_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      sat_q       <= sat_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  assign bus.in_ready  = (state_q == st_accum);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign busy          = (state_q != st_idle);
  assign neuron_idx    = idx_q;
  assign sat_flag      = sat_q;
  assign done          = done_q;

endmodule

// File: tb/tb_agg_ctrl.sv
// Purpose: randomized and directed checking of agg_ctrl against a saturating-sum/ReLU reference model.
// Latency: expects out_valid two cycles after the last input handshake and done one cycle after the last output.
// Backpressure: exercises input bubbles and output stalls of fixed and random length.
module tb_agg_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] cfg_fanin;
  logic [7:0] cfg_neurons;
  logic [7:0] neuron_idx;
  logic       sat_flag;
  logic       busy;
  logic       done;

  agg_ctrl_if #(.agg_width(12)) bus ();

  agg_ctrl #(.agg_width(12), .cnt_width(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cfg_fanin  (cfg_fanin),
    .cfg_neurons(cfg_neurons),
    .bus        (bus),
    .neuron_idx (neuron_idx),
    .sat_flag   (sat_flag),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int stim_q[$];
  bit vld_q[$];
  int stall_fixed;
  int bubble_pct;
  bit poke_start;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int next_val();
    if (stim_q.size() > 0) return stim_q.pop_front();
    if ($urandom_range(0, 1) == 1) return int'($urandom_range(0, 600)) - 300;
    return int'($urandom_range(0, 4095)) - 2048;
  endfunction

  // Drives one whole layer and checks every output against a plain-integer model.
  task automatic run_layer(input int fanin, input int neurons);
    int  acc;
    int  cnt;
    int  d;
    int  expv;
    int  zrun;
    int  stalls;
    bit  sat;
    bit  v;
    start       = 1'b1;
    cfg_fanin   = 8'(fanin);
    cfg_neurons = 8'(neurons);
    step();
    start       = 1'b0;
    cfg_fanin   = 8'($urandom);
    cfg_neurons = 8'($urandom);
    if (fanin == 0 || neurons == 0) begin
      chk_eq("degen_done", 32'(done), 32'd1);
      chk_eq("degen_busy", 32'(busy), 32'd0);
      step();
      chk_eq("degen_done_clr", 32'(done), 32'd0);
      chk_eq("degen_busy2", 32'(busy), 32'd0);
      return;
    end
    chk_eq("start_busy", 32'(busy), 32'd1);
    for (int n = 0; n < neurons; n++) begin
      acc  = 0;
      sat  = 1'b0;
      cnt  = 0;
      zrun = 0;
      while (cnt < fanin) begin
        if (vld_q.size() > 0) v = vld_q.pop_front();
        else v = ($urandom_range(0, 99) >= bubble_pct);
        if (!v) zrun++;
        if (zrun > 3) v = 1'b1;
        if (v) zrun = 0;
        chk_eq("accum_in_rdy", 32'(bus.in_ready), 32'd1);
        chk_eq("accum_out_vld", 32'(bus.out_valid), 32'd0);
        d = 0;
        if (v) begin
          d = next_val();
          bus.in_data = 12'(d);
        end else begin
          bus.in_data = 12'($urandom);
        end
        bus.in_valid = v;
        if (poke_start && !v) begin
          start       = 1'b1;
          cfg_fanin   = 8'($urandom_range(1, 255));
          cfg_neurons = 8'($urandom_range(1, 255));
        end
        step();
        start = 1'b0;
        if (v) begin
          acc = acc + d;
          if (acc > 2047) begin
            acc = 2047;
            sat = 1'b1;
          end else if (acc < -2048) begin
            acc = -2048;
            sat = 1'b1;
          end
          cnt++;
        end
      end
      bus.in_valid = 1'b0;
      chk_eq("act_in_rdy", 32'(bus.in_ready), 32'd0);
      chk_eq("act_out_vld", 32'(bus.out_valid), 32'd0);
      step();
      expv = (acc < 0) ? 0 : acc;
      chk_eq("out_vld", 32'(bus.out_valid), 32'd1);
      chk_eq("out_dat", 32'(bus.out_data), 32'(expv));
      chk_eq("out_idx", 32'(neuron_idx), 32'(n));
      chk_eq("out_sat", 32'(sat_flag), 32'(sat));
      stalls = (stall_fixed >= 0) ? stall_fixed : int'($urandom_range(0, 3));
      for (int s = 0; s < stalls; s++) begin
        bus.out_ready = 1'b0;
        step();
        chk_eq("stall_vld", 32'(bus.out_valid), 32'd1);
        chk_eq("stall_dat", 32'(bus.out_data), 32'(expv));
        chk_eq("stall_in_rdy", 32'(bus.in_ready), 32'd0);
      end
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      chk_eq("post_out_vld", 32'(bus.out_valid), 32'd0);
      if (n == neurons - 1) begin
        chk_eq("done_pulse", 32'(done), 32'd1);
        chk_eq("done_busy", 32'(busy), 32'd0);
        chk_eq("done_dat_hold", 32'(bus.out_data), 32'(expv));
        step();
        chk_eq("done_clr", 32'(done), 32'd0);
      end else begin
        chk_eq("next_done", 32'(done), 32'd0);
        chk_eq("next_in_rdy", 32'(bus.in_ready), 32'd1);
        chk_eq("next_idx", 32'(neuron_idx), 32'(n + 1));
        chk_eq("next_sat", 32'(sat_flag), 32'd0);
      end
    end
  endtask

  initial begin
    rst           = 1'b0;
    start         = 1'b0;
    cfg_fanin     = '0;
    cfg_neurons   = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    stall_fixed   = 0;
    bubble_pct    = 0;
    poke_start    = 1'b0;
    #12;
    chk_eq("rst_busy", 32'(busy), 32'd0);
    chk_eq("rst_in_rdy", 32'(bus.in_ready), 32'd0);
    chk_eq("rst_out_vld", 32'(bus.out_valid), 32'd0);
    chk_eq("rst_out_dat", 32'(bus.out_data), 32'd0);
    chk_eq("rst_idx", 32'(neuron_idx), 32'd0);
    chk_eq("rst_sat", 32'(sat_flag), 32'd0);
    chk_eq("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    step();

    // basic layer: expects 10 then ReLU(-6)=0
    stim_q = '{5, 7, -2, -10, 3, 1};
    run_layer(3, 2);

    // saturation both directions
    stim_q = '{2000, 2000, -2000, -2000};
    run_layer(2, 2);

    // output backpressure
    stall_fixed = 5;
    run_layer(2, 1);
    stall_fixed = 0;

    // input bubbles
    vld_q = '{1, 0, 0, 1, 0, 1};
    run_layer(3, 1);

    // degenerate configs
    run_layer(0, 3);
    run_layer(4, 0);

    // start poked during ACCUM must be ignored
    poke_start = 1'b1;
    bubble_pct = 40;
    run_layer(5, 2);
    poke_start = 1'b0;

    // maximum fan-in
    bubble_pct = 0;
    run_layer(255, 1);

    // randomized layers
    stall_fixed = -1;
    bubble_pct  = 30;
    for (int i = 0; i < 20; i++) begin
      run_layer(int'($urandom_range(1, 10)), int'($urandom_range(1, 4)));
    end
    stall_fixed = 0;
    bubble_pct  = 0;

    // leave a nonzero result behind, then reset mid-ACCUM with sat_flag set
    stim_q = '{100};
    run_layer(1, 1);
    start       = 1'b1;
    cfg_fanin   = 8'd4;
    cfg_neurons = 8'd1;
    step();
    start        = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 12'd2000;
    step();
    step();
    bus.in_valid = 1'b0;
    chk_eq("pre_rst_sat", 32'(sat_flag), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk_eq("mid_rst_busy", 32'(busy), 32'd0);
    chk_eq("mid_rst_in_rdy", 32'(bus.in_ready), 32'd0);
    chk_eq("mid_rst_out_vld", 32'(bus.out_valid), 32'd0);
    chk_eq("mid_rst_out_dat", 32'(bus.out_data), 32'd0);
    chk_eq("mid_rst_idx", 32'(neuron_idx), 32'd0);
    chk_eq("mid_rst_sat", 32'(sat_flag), 32'd0);
    chk_eq("mid_rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    step();
    chk_eq("post_rst_done", 32'(done), 32'd0);
    stim_q = '{1, 2, 3, 4};
    run_layer(4, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
